// File: rtl/param_vpis_pkg.sv
// Shared types and helpers for the vectored priority interrupt system.
// Holds the request FSM states and the channel-to-vector rule.
package param_vpis_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Width of a channel number: a single channel still needs one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned N_CH_DEF = 4;
    localparam int unsigned CH_W     = ch_width(N_CH_DEF);

    // Base + stride rule; the caller truncates to its vector width.
    function automatic logic [31:0] vec_of(input logic [31:0] ch,
                                           input logic [31:0] base,
                                           input logic [31:0] stride);
        return base + ch * stride;
    endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Priority encoder: lowest set index wins (index 0 is the highest priority).
// Reports the winning index and whether any request bit is set.
module prio_enc_n
    import param_vpis_pkg::*;
#(
    parameter  int unsigned N = 4,
    localparam int unsigned W = ch_width(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        idx   = '0;
        valid = 1'b0;
        // Scan from the lowest priority upward so the lowest index overwrites last.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_vpis.sv
// Parametrised vectored priority interrupt system with mask, nesting and
// a request/acknowledge handshake towards the pipeline controller.
module param_vpis
    import param_vpis_pkg::*;
#(
    parameter int unsigned       N_CH       = 4,
    parameter int unsigned       VEC_W      = 8,
    parameter logic [VEC_W-1:0]  VEC_BASE   = 8'hF0,
    parameter int unsigned       VEC_STRIDE = 4
) (
    input  logic              g_clk,
    input  logic              g_clr,
    input  logic [N_CH-1:0]   irq_in,
    input  logic [N_CH-1:0]   mode_edge,
    input  logic              mask_ld,
    input  logic [N_CH-1:0]   mask_in,
    input  logic              ien,
    input  logic              int_ack,
    input  logic              int_ret,
    output logic              i_pending,
    output logic [VEC_W-1:0]  vector,
    output logic [N_CH-1:0]   in_service
);

    localparam int unsigned SEL_W = ch_width(N_CH);

    state_t            state;
    logic [SEL_W-1:0]  sel;
    logic [N_CH-1:0]   irq_q;
    logic [N_CH-1:0]   pend;
    logic [N_CH-1:0]   mask;

    logic [N_CH-1:0]   rise;
    logic [N_CH-1:0]   allow;
    logic [N_CH-1:0]   eligible;
    logic [N_CH-1:0]   ack_set;
    logic [N_CH-1:0]   ret_clr;
    logic [N_CH-1:0]   pend_next;
    logic [SEL_W-1:0]  top_idx;
    logic              top_valid;
    logic [SEL_W-1:0]  win_idx;
    logic              win_valid;
    logic              ack_hit;

    assign rise    = irq_in & ~irq_q;
    assign ack_hit = (state == REQ) && int_ack;

    // Highest-priority channel in service: target of int_ret and the preemption limit.
    prio_enc_n #(.N(N_CH)) u_is_enc (
        .req   (in_service),
        .idx   (top_idx),
        .valid (top_valid)
    );

    always_comb begin
        allow   = '0;
        ack_set = '0;
        ret_clr = '0;
        for (int c = 0; c < N_CH; c++) begin
            allow[c]   = !top_valid || (SEL_W'(c) < top_idx);
            ack_set[c] = ack_hit && (SEL_W'(c) == sel);
            ret_clr[c] = int_ret && top_valid && (SEL_W'(c) == top_idx);
        end
    end

    assign eligible = pend & mask & allow;

    prio_enc_n #(.N(N_CH)) u_el_enc (
        .req   (eligible),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // A fresh edge on the acknowledged channel wins over the clear, so it is not lost.
    always_comb begin
        pend_next = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (mode_edge[c])
                pend_next[c] = rise[c] | (pend[c] & ~ack_set[c]);
            else
                pend_next[c] = irq_in[c];
        end
    end

    always_ff @(posedge g_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!g_clr) begin
            irq_q      <= '0;
            pend       <= '0;
            mask       <= '1;
            in_service <= '0;
        end else begin
            irq_q      <= irq_in;
            pend       <= pend_next;
            if (mask_ld)
                mask <= mask_in;
            // int_ret retires its bit before int_ack marks the new one.
            in_service <= (in_service & ~ret_clr) | ack_set;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_clr) begin
            state     <= IDLE;
            sel       <= '0;
            i_pending <= 1'b0;
            vector    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ien && win_valid) begin
                        sel       <= win_idx;
                        vector    <= VEC_W'(vec_of(32'(win_idx), 32'(VEC_BASE), 32'(VEC_STRIDE)));
                        i_pending <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // sel and vector stay frozen until the controller takes or loses the request.
                    if (int_ack) begin
                        i_pending <= 1'b0;
                        state     <= IDLE;
                    end else if (!ien) begin
                        i_pending <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    i_pending <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_vpis.sv
// Directed bench for param_vpis (N_CH=4, base F0, stride 4).
// Expected values are hand-derived from the request/ack timing rules.
module tb_param_vpis;

    logic       g_clk = 1'b0;
    logic       g_clr;
    logic [3:0] irq_in;
    logic [3:0] mode_edge;
    logic       mask_ld;
    logic [3:0] mask_in;
    logic       ien;
    logic       int_ack;
    logic       int_ret;
    logic       i_pending;
    logic [7:0] vector;
    logic [3:0] in_service;

    int checks = 0;
    int errors = 0;

    param_vpis #(
        .N_CH       (4),
        .VEC_W      (8),
        .VEC_BASE   (8'hF0),
        .VEC_STRIDE (4)
    ) dut (
        .g_clk      (g_clk),
        .g_clr      (g_clr),
        .irq_in     (irq_in),
        .mode_edge  (mode_edge),
        .mask_ld    (mask_ld),
        .mask_in    (mask_in),
        .ien        (ien),
        .int_ack    (int_ack),
        .int_ret    (int_ret),
        .i_pending  (i_pending),
        .vector     (vector),
        .in_service (in_service)
    );

    always #5 g_clk = ~g_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        g_clr     = 1'b0;
        irq_in    = 4'b0000;
        mode_edge = 4'b1111;
        mask_ld   = 1'b0;
        mask_in   = 4'b1111;
        ien       = 1'b0;
        int_ack   = 1'b0;
        int_ret   = 1'b0;
        tick();
        tick();
        check("reset_pending", i_pending, 1'b0);
        check("reset_vector", vector, 8'h00);
        check("reset_in_service", in_service, 4'b0000);
        g_clr = 1'b1;
        ien   = 1'b1;
        tick();

        // Edge ch2: pend at k, request at k+1.
        irq_in = 4'b0100;
        tick();
        check("ch2_k_no_req", i_pending, 1'b0);
        tick();
        check("ch2_req", i_pending, 1'b1);
        check("ch2_vec", vector, 8'hF8);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("ch2_ack_pending", i_pending, 1'b0);
        check("ch2_ack_is", in_service, 4'b0100);
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        check("ch2_ret_is", in_service, 4'b0000);
        tick();
        tick();
        check("ch2_pend_cleared", i_pending, 1'b0);
        irq_in = 4'b0000;
        tick();

        // Priority and lock: ch3+ch1 together, ch0 arrives during REQ.
        irq_in = 4'b1010;
        tick();
        tick();
        check("prio_req", i_pending, 1'b1);
        check("prio_vec_f4", vector, 8'hF4);
        irq_in = 4'b1011;
        tick();
        tick();
        check("lock_vec_f4", vector, 8'hF4);
        check("lock_pending", i_pending, 1'b1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("ack_ch1_is", in_service, 4'b0010);
        check("ack_ch1_pending", i_pending, 1'b0);
        tick();
        check("nest_ch0_req", i_pending, 1'b1);
        check("nest_ch0_vec", vector, 8'hF0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("nest_is_0011", in_service, 4'b0011);
        int_ret = 1'b1;
        tick();
        check("ret1_is_0010", in_service, 4'b0010);
        check("ch3_blocked", i_pending, 1'b0);
        tick();
        int_ret = 1'b0;
        check("ret2_is_0000", in_service, 4'b0000);
        tick();
        check("ch3_req", i_pending, 1'b1);
        check("ch3_vec_fc", vector, 8'hFC);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("ch3_ack_is", in_service, 4'b1000);
        int_ret = 1'b1;
        irq_in  = 4'b0000;
        tick();
        int_ret = 1'b0;
        check("ch3_ret_is", in_service, 4'b0000);

        // Level mode ch0 re-requests after each ack/ret pair.
        mode_edge = 4'b1110;
        irq_in    = 4'b0001;
        tick();
        tick();
        check("lvl_req1", i_pending, 1'b1);
        check("lvl_vec1", vector, 8'hF0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("lvl_ack1_is", in_service, 4'b0001);
        tick();
        tick();
        check("lvl_blocked_in_service", i_pending, 1'b0);
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        tick();
        check("lvl_req2", i_pending, 1'b1);
        check("lvl_vec2", vector, 8'hF0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        irq_in  = 4'b0000;
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        mode_edge = 4'b1111;
        tick();

        // Edge mode ch0 held high requests only once.
        irq_in = 4'b0001;
        tick();
        tick();
        check("edge0_req", i_pending, 1'b1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        tick();
        tick();
        check("edge0_once", i_pending, 1'b0);
        irq_in = 4'b0000;
        tick();

        // Mask blocks eligibility; pend still latches; old mask governs the load cycle.
        mask_in = 4'b1101;
        mask_ld = 1'b1;
        tick();
        mask_ld = 1'b0;
        irq_in  = 4'b0010;
        tick();
        tick();
        tick();
        check("masked_no_req", i_pending, 1'b0);
        mask_in = 4'b1111;
        mask_ld = 1'b1;
        tick();
        mask_ld = 1'b0;
        check("old_mask_governs", i_pending, 1'b0);
        tick();
        check("unmask_req", i_pending, 1'b1);
        check("unmask_vec", vector, 8'hF4);
        ien = 1'b0;
        tick();
        check("ien_withdraw", i_pending, 1'b0);
        ien = 1'b1;
        tick();
        check("pend1_kept_req", i_pending, 1'b1);
        check("pend1_kept_vec", vector, 8'hF4);

        // int_ret and int_ack together: ret clears ch1, ack sets ch0.
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("ack_ch1_again", in_service, 4'b0010);
        irq_in = 4'b0011;
        tick();
        tick();
        check("ch0_over_ch1_vec", vector, 8'hF0);
        int_ack = 1'b1;
        int_ret = 1'b1;
        tick();
        int_ack = 1'b0;
        int_ret = 1'b0;
        check("ret_ack_same_cycle", in_service, 4'b0001);
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        irq_in = 4'b0000;
        tick();

        // New edge on sel in the ack cycle keeps pend set.
        irq_in = 4'b0001;
        tick();
        tick();
        check("edge_ack_req", i_pending, 1'b1);
        irq_in = 4'b0000;
        tick();
        irq_in  = 4'b0001;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("edge_ack_is", in_service, 4'b0001);
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        tick();
        check("edge_not_lost", i_pending, 1'b1);
        check("edge_not_lost_vec", vector, 8'hF0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        irq_in  = 4'b0000;
        tick();

        // int_ack in IDLE is ignored.
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("idle_ack_ignored", in_service, 4'b0000);

        // Reset mid-REQ restores the mask to all ones.
        mask_in = 4'b1101;
        mask_ld = 1'b1;
        tick();
        mask_ld = 1'b0;
        irq_in  = 4'b1000;
        tick();
        tick();
        check("pre_reset_vec", vector, 8'hFC);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        irq_in  = 4'b0001;
        tick();
        tick();
        check("pre_reset_req", i_pending, 1'b1);
        g_clr  = 1'b0;
        irq_in = 4'b0010;
        tick();
        g_clr = 1'b1;
        check("mid_reset_pending", i_pending, 1'b0);
        check("mid_reset_vector", vector, 8'h00);
        check("mid_reset_is", in_service, 4'b0000);
        tick();
        tick();
        check("mask_reset_req", i_pending, 1'b1);
        check("mask_reset_vec", vector, 8'hF4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
